// File: rtl/cmult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cmult_pipe
// Description : Three-stage pipelined signed complex multiplier with optional
//               conjugation, rounding, saturation and overflow flagging.
// Revision    : 1.0
// ============================================================================
module cmult_pipe #(
    parameter int IN_W  = 16,
    parameter int W_W   = 16,
    parameter int OUT_W = 16,
    parameter int FRAC  = 8,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_r,
    input  logic signed [IN_W-1:0]  in_i,
    input  logic signed [W_W-1:0]   w_r,
    input  logic signed [W_W-1:0]   w_i,
    input  logic                    in_conj,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_r,
    output logic signed [OUT_W-1:0] out_i,
    output logic                    out_ovf,
    output logic                    ovf_sticky
);

    localparam int c_pw = IN_W + W_W;
    // Two guard bits above the product width: one for the sum, one for the rounding add.
    localparam int c_sw = IN_W + W_W + 2;

    localparam logic signed [c_sw-1:0] c_rnd = (ROUND != 0) ? (c_sw'(1) << (FRAC - 1)) : c_sw'(0);
    localparam logic signed [c_sw-1:0] c_max = (c_sw'(1) << (OUT_W - 1)) - c_sw'(1);
    localparam logic signed [c_sw-1:0] c_min = -(c_sw'(1) << (OUT_W - 1));

    logic                   r_s1_valid;
    logic signed [IN_W-1:0] r_s1_ar;
    logic signed [IN_W-1:0] r_s1_ai;
    logic signed [W_W-1:0]  r_s1_br;
    logic signed [W_W-1:0]  r_s1_bi;
    logic                   r_s1_conj;

    logic                   r_s2_valid;
    logic signed [c_pw-1:0] r_s2_rr;
    logic signed [c_pw-1:0] r_s2_ii;
    logic signed [c_pw-1:0] r_s2_ri;
    logic signed [c_pw-1:0] r_s2_ir;
    logic                   r_s2_conj;

    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_r;
    logic signed [OUT_W-1:0] r_out_i;
    logic                    r_out_ovf;
    logic                    r_sticky;

    logic                    w_en;
    logic signed [c_sw-1:0]  w_sum_re;
    logic signed [c_sw-1:0]  w_sum_im;
    logic [OUT_W:0]          w_fit_re;
    logic [OUT_W:0]          w_fit_im;
    logic                    w_ovf;

    // Returns {overflow, value}: round, floor-shift, then clamp or wrap.
    function automatic logic [OUT_W:0] fit(input logic signed [c_sw-1:0] x);
        logic signed [c_sw-1:0] t;
        logic [OUT_W-1:0]       v;
        logic                   o;
        t = (x + c_rnd) >>> FRAC;
        o = (t > c_max) || (t < c_min);
        v = t[OUT_W-1:0];
        if (SAT != 0) begin
            if (t > c_max) begin
                v = c_max[OUT_W-1:0];
            end else if (t < c_min) begin
                v = c_min[OUT_W-1:0];
            end
        end
        return {o, v};
    endfunction

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    always_comb begin
        w_sum_re = '0;
        w_sum_im = '0;
        if (r_s2_conj) begin
            w_sum_re = c_sw'(r_s2_rr) + c_sw'(r_s2_ii);
            w_sum_im = c_sw'(r_s2_ir) - c_sw'(r_s2_ri);
        end else begin
            w_sum_re = c_sw'(r_s2_rr) - c_sw'(r_s2_ii);
            w_sum_im = c_sw'(r_s2_ri) + c_sw'(r_s2_ir);
        end
    end

    assign w_fit_re = fit(w_sum_re);
    assign w_fit_im = fit(w_sum_im);
    assign w_ovf    = w_fit_re[OUT_W] || w_fit_im[OUT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_ar     <= '0;
            r_s1_ai     <= '0;
            r_s1_br     <= '0;
            r_s1_bi     <= '0;
            r_s1_conj   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_rr     <= '0;
            r_s2_ii     <= '0;
            r_s2_ri     <= '0;
            r_s2_ir     <= '0;
            r_s2_conj   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_i     <= '0;
            r_out_ovf   <= 1'b0;
            r_sticky    <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_ar    <= in_r;
            r_s1_ai    <= in_i;
            r_s1_br    <= w_r;
            r_s1_bi    <= w_i;
            r_s1_conj  <= in_conj;

            // Operands are widened first so the full product (incl. min*min) fits.
            r_s2_valid <= r_s1_valid;
            r_s2_rr    <= c_pw'(r_s1_ar) * c_pw'(r_s1_br);
            r_s2_ii    <= c_pw'(r_s1_ai) * c_pw'(r_s1_bi);
            r_s2_ri    <= c_pw'(r_s1_ar) * c_pw'(r_s1_bi);
            r_s2_ir    <= c_pw'(r_s1_ai) * c_pw'(r_s1_br);
            r_s2_conj  <= r_s1_conj;

            r_out_valid <= r_s2_valid;
            r_out_ovf   <= r_s2_valid && w_ovf;
            r_sticky    <= r_sticky || (r_s2_valid && w_ovf);
            if (r_s2_valid) begin
                r_out_r <= w_fit_re[OUT_W-1:0];
                r_out_i <= w_fit_im[OUT_W-1:0];
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_r      = r_out_r;
    assign out_i      = r_out_i;
    assign out_ovf    = r_out_ovf;
    assign ovf_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_cmult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmult_pipe
// Description : Self-checking bench for cmult_pipe, comparing a round/saturate
//               instance and a truncate/wrap instance against a reference model.
// Revision    : 1.0
// ============================================================================
module tb_cmult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_conj = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [15:0] in_r = '0;
    logic signed [15:0] in_i = '0;
    logic signed [15:0] w_r = '0;
    logic signed [15:0] w_i = '0;

    logic               in_ready_a, out_valid_a, ovf_a, sticky_a;
    logic               in_ready_b, out_valid_b, ovf_b, sticky_b;
    logic signed [15:0] out_r_a, out_i_a, out_r_b, out_i_b;

    cmult_pipe #(.IN_W(16), .W_W(16), .OUT_W(16), .FRAC(8), .ROUND(1), .SAT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_r(in_r), .in_i(in_i), .w_r(w_r), .w_i(w_i), .in_conj(in_conj),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_r(out_r_a), .out_i(out_i_a),
        .out_ovf(ovf_a), .ovf_sticky(sticky_a)
    );

    cmult_pipe #(.IN_W(16), .W_W(16), .OUT_W(16), .FRAC(8), .ROUND(0), .SAT(0)) dut_tw (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_r(in_r), .in_i(in_i), .w_r(w_r), .w_i(w_i), .in_conj(in_conj),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_r(out_r_b), .out_i(out_i_b),
        .out_ovf(ovf_b), .ovf_sticky(sticky_b)
    );

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] i;
        logic        ovf;
    } res_t;

    res_t exp_a[$], exp_b[$], got_a[$], got_b[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Scale by 2^-8 with floor semantics, then clamp or wrap to 16 bits.
    function automatic logic [16:0] fit(input longint x, input bit rnd, input bit sat);
        longint y;
        longint q;
        y = x + (rnd ? 128 : 0);
        if (y >= 0) q = y / 256;
        else        q = -((-y + 255) / 256);
        if (q > 32767)  return {1'b1, sat ? 16'h7FFF : q[15:0]};
        if (q < -32768) return {1'b1, sat ? 16'h8000 : q[15:0]};
        return {1'b0, q[15:0]};
    endfunction

    function automatic res_t model(input logic signed [15:0] ar, ai, br, bi,
                                   input logic conj, input bit rnd, input bit sat);
        longint re, im;
        logic [16:0] fr, fi;
        if (conj) begin
            re = longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
            im = longint'(ai) * longint'(br) - longint'(ar) * longint'(bi);
        end else begin
            re = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
            im = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
        end
        fr = fit(re, rnd, sat);
        fi = fit(im, rnd, sat);
        return {fr[15:0], fi[15:0], fr[16] | fi[16]};
    endfunction

    function automatic logic signed [15:0] rnd16();
        logic [31:0] u;
        u = $urandom;
        case ($urandom_range(0, 7))
            0:       return 16'sh8000;
            1:       return 16'sh7FFF;
            default: return u[15:0];
        endcase
    endfunction

    always @(negedge clk) begin
        if (out_valid_a && out_ready) got_a.push_back({out_r_a, out_i_a, ovf_a});
        if (out_valid_b && out_ready) got_b.push_back({out_r_b, out_i_b, ovf_b});
    end

    task automatic send(input logic signed [15:0] ar, ai, br, bi, input logic conj);
        int n = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_r = ar; in_i = ai; w_r = br; w_i = bi; in_conj = conj;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready_a);
        end else begin
            exp_a.push_back(model(ar, ai, br, bi, conj, 1'b1, 1'b1));
            exp_b.push_back(model(ar, ai, br, bi, conj, 1'b0, 1'b0));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_out(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < 200 && (got_a.size() < n || got_b.size() < n); k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic flush();
        idle(6);
        exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) begin @(posedge clk); end
        #1;
        n_checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b/%b required 0", out_valid_a, out_valid_b); end
        n_checks++; if (out_r_a !== 16'd0 || out_i_a !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %h,%h required 0,0", out_r_a, out_i_a); end
        n_checks++; if (ovf_a !== 1'b0 || sticky_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got ovf %b sticky %b required 0", ovf_a, sticky_a); end
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready_a); end
        reset = 1'b0;
        idle(4);
        n_checks++; if (out_valid_a !== 1'b0 || got_a.size() != 0) begin n_fail++; $display("FAIL reset_override: got valid %b count %0d required 0", out_valid_a, got_a.size()); end
        flush();
    endtask

    task automatic test_identity();
        int lat = 1;
        send(16'sd100, -16'sd50, 16'sd256, 16'sd0, 1'b0);
        in_valid = 1'b0;
        while (!out_valid_a && lat < 20) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL identity_latency: got %0d required 3", lat); end
        n_checks++; if (out_r_a !== 16'sd100 || out_i_a !== -16'sd50 || ovf_a !== 1'b0) begin
            n_fail++; $display("FAIL identity_value: got (%0d,%0d,%b) required (100,-50,0)", out_r_a, out_i_a, ovf_a); end
        flush();
    endtask

    task automatic test_rotate_back_to_back();
        int er[4] = '{-50, 50, -50, 50};
        int ei[4] = '{100, -100, 100, -100};
        for (int k = 0; k < 4; k++) send(16'sd100, 16'sd50, 16'sd0, 16'sd256, k[0]);
        wait_out(4);
        n_checks++; if (got_a.size() != 4 || got_b.size() != 4) begin n_fail++; $display("FAIL rotate_count: got %0d/%0d required 4", got_a.size(), got_b.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got_a[k].r !== 16'(er[k]) || got_a[k].i !== 16'(ei[k]) || got_b[k].r !== 16'(er[k]) || got_b[k].i !== 16'(ei[k])) begin
                n_fail++; $display("FAIL rotate_%0d: got (%0d,%0d)/(%0d,%0d) required (%0d,%0d)", k,
                    $signed(got_a[k].r), $signed(got_a[k].i), $signed(got_b[k].r), $signed(got_b[k].i), er[k], ei[k]); end
        end
        flush();
    endtask

    task automatic test_rounding();
        send(16'sd3, -16'sd3, 16'sd128, 16'sd0, 1'b0);
        wait_out(1);
        n_checks++; if (got_a.size() < 1 || got_a[0] !== {16'sd2, -16'sd1, 1'b0}) begin
            n_fail++; $display("FAIL round_half_up: got %h required (2,-1,0)", got_a.size() ? got_a[0] : 'x); end
        n_checks++; if (got_b.size() < 1 || got_b[0] !== {16'sd1, -16'sd2, 1'b0}) begin
            n_fail++; $display("FAIL round_truncate: got %h required (1,-2,0)", got_b.size() ? got_b[0] : 'x); end
        n_checks++; if (sticky_a !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b required 0", sticky_a); end
        flush();
    endtask

    task automatic test_saturation();
        int n = 0;
        send(16'sh7FFF, 16'sh8000, 16'sd512, 16'sd0, 1'b0);
        in_valid = 1'b0;
        while (!out_valid_a && n < 20) begin @(posedge clk); #1; n++; end
        n_checks++; if (out_valid_a !== 1'b1 || sticky_a !== 1'b1) begin
            n_fail++; $display("FAIL sticky_same_cycle: got valid %b sticky %b required 1,1", out_valid_a, sticky_a); end
        wait_out(1);
        n_checks++; if (got_a.size() < 1 || got_a[0] !== {16'sh7FFF, 16'sh8000, 1'b1}) begin
            n_fail++; $display("FAIL saturate: got %h required (32767,-32768,1)", got_a.size() ? got_a[0] : 'x); end
        n_checks++; if (got_b.size() < 1 || got_b[0] !== {-16'sd2, 16'sd0, 1'b1}) begin
            n_fail++; $display("FAIL wrap: got %h required (-2,0,1)", got_b.size() ? got_b[0] : 'x); end
        idle(3);
        n_checks++; if (sticky_a !== 1'b1 || sticky_b !== 1'b1) begin
            n_fail++; $display("FAIL sticky_hold: got %b/%b required 1", sticky_a, sticky_b); end
        flush();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(0, 1)));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_out(40);
        n_checks++; if (got_a.size() != 40 || got_b.size() != 40) begin n_fail++; $display("FAIL random_count: got %0d/%0d required 40", got_a.size(), got_b.size()); end
        else for (int k = 0; k < 40; k++) begin
            n_checks++;
            if (got_a[k] !== exp_a[k] || got_b[k] !== exp_b[k]) begin
                n_fail++; $display("FAIL random_%0d: got %h/%h required %h/%h", k, got_a[k], got_b[k], exp_a[k], exp_b[k]); end
        end
        flush();
    endtask

    task automatic test_backpressure();
        int n_stall = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) send(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
            end
            begin
                bit prev_stall = 1'b0;
                logic [33:0] held = '0;
                for (int c = 0; c < 20; c++) begin
                    out_ready = !(c >= 4 && c <= 8);
                    @(negedge clk);
                    if (prev_stall) begin
                        n_checks++;
                        if ({out_r_a, out_i_a, ovf_a, out_valid_a} !== held) begin
                            n_fail++; $display("FAIL stall_stable: got %h required %h", {out_r_a, out_i_a, ovf_a, out_valid_a}, held); end
                    end
                    prev_stall = 1'b0;
                    if (!out_ready && out_valid_a) begin
                        n_stall++; n_checks++;
                        if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b required 0", in_ready_a); end
                        prev_stall = 1'b1;
                        held = {out_r_a, out_i_a, ovf_a, out_valid_a};
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        n_checks++; if (n_stall == 0) begin n_fail++; $display("FAIL stall_seen: got 0 stalled cycles required >0"); end
        wait_out(10);
        n_checks++; if (got_a.size() != 10 || got_b.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d/%0d required 10", got_a.size(), got_b.size()); end
        else for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (got_a[k] !== exp_a[k] || got_b[k] !== exp_b[k]) begin
                n_fail++; $display("FAIL bp_order_%0d: got %h/%h required %h/%h", k, got_a[k], got_b[k], exp_a[k], exp_b[k]); end
        end
        flush();
    endtask

    task automatic test_reset_midstream();
        int cnt;
        for (int k = 0; k < 3; k++) send(16'sh7FFF, 16'sh7FFF, 16'sd512, 16'sd512, 1'b0);
        reset = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid_a !== 1'b0 || sticky_a !== 1'b0 || in_ready_a !== 1'b1) begin
            n_fail++; $display("FAIL midreset_state: got valid %b sticky %b in_ready %b required 0,0,1", out_valid_a, sticky_a, in_ready_a); end
        cnt = got_a.size();
        for (int c = 0; c < 8; c++) begin
            n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL midreset_stale_%0d: got valid %b required 0", c, out_valid_a); end
            @(posedge clk); #1;
        end
        n_checks++; if (got_a.size() != cnt) begin n_fail++; $display("FAIL midreset_count: got %0d required %0d", got_a.size(), cnt); end
        exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
        send(rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);
        wait_out(1);
        n_checks++; if (got_a.size() != 1 || got_a[0] !== exp_a[0] || got_b[0] !== exp_b[0]) begin
            n_fail++; $display("FAIL midreset_resume: got %0d results, required 1 matching %h", got_a.size(), exp_a[0]); end
        flush();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_identity();
        test_rotate_back_to_back();
        test_rounding();
        test_saturation();
        test_random();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
